// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Multi-cycle subtractor computing d = a - b - bin, DIGIT bits per clock,
// least-significant slice first. The borrow between slices is held in a
// register, so only a DIGIT-bit ripple of full-subtractor cells is built in
// logic regardless of WIDTH. A start/busy/done handshake frames each operation.
//
// Parameters
//   WIDTH : operand/result width in bits (>= 2)
//   DIGIT : bits processed per clock, must divide WIDTH
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while busy=0
//   a      in   minuend, captured with an accepted start
//   b      in   subtrahend, captured with an accepted start
//   bin    in   borrow-in, captured with an accepted start
//   busy   out  high while a subtraction is in progress
//   done   out  one-cycle pulse when results become valid
//   d      out  difference modulo 2^WIDTH
//   bout   out  borrow out of the MSB (unsigned a < b + bin)
//   ovf    out  signed two's-complement overflow
//   zero   out  high when d == 0
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Reject unusable configurations at elaboration time.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_subtractor: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg;       // minuend, shifted right one slice per RUN edge
  logic [WIDTH-1:0]   b_reg;       // subtrahend, shifted alongside a_reg
  logic               borrow_reg;  // borrow into the next slice
  logic [WIDTH-1:0]   acc_reg;     // partial difference, filled from the top
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   d_reg;
  logic               bout_reg;
  logic               ovf_reg;
  logic               zero_reg;

  // ---------------------------------------------------------------------------
  // One DIGIT-bit slice of full-subtractor cells.
  // br_chain[gi] is the borrow into cell gi; br_chain[DIGIT] leaves the slice.
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] x_slice;
  logic [DIGIT-1:0] y_slice;
  logic [DIGIT-1:0] diff_slice;
  logic [DIGIT:0]   br_chain;

  assign x_slice     = a_reg[DIGIT-1:0];
  assign y_slice     = b_reg[DIGIT-1:0];
  assign br_chain[0] = borrow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_cell
      assign diff_slice[gi]   = x_slice[gi] ^ y_slice[gi] ^ br_chain[gi];
      assign br_chain[gi + 1] = (~x_slice[gi] & y_slice[gi]) |
                                (~(x_slice[gi] ^ y_slice[gi]) & br_chain[gi]);
    end
  endgenerate

  // The new slice enters at the top of the accumulator, so after N edges the
  // first slice has walked down to bit 0 and the word is in natural order.
  logic [WIDTH-1:0] acc_shift;
  assign acc_shift = (acc_reg >> DIGIT) | (WIDTH'(diff_slice) << (WIDTH - DIGIT));

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      d_reg      <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_RUN;
          end
        end

        ST_RUN: begin
          // start is deliberately not looked at here: no queueing.
          a_reg      <= a_reg >> DIGIT;
          b_reg      <= b_reg >> DIGIT;
          borrow_reg <= br_chain[DIGIT];
          acc_reg    <= acc_shift;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            // Last slice: publish all results together so d never shows a
            // partial word. Overflow is the borrow into the MSB cell XOR the
            // borrow out of it.
            d_reg     <= acc_shift;
            bout_reg  <= br_chain[DIGIT];
            ovf_reg   <= br_chain[DIGIT-1] ^ br_chain[DIGIT];
            zero_reg  <= (acc_shift == '0);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            // Back-to-back: done falls and busy rises on the same edge.
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_RUN;
          end else begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign d    = d_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor. Three instances share one clock:
// WIDTH=8/DIGIT=1 (table vectors, handshake and reset cases), WIDTH=3/DIGIT=1
// (all 128 operand combinations) and WIDTH=16/DIGIT=4 (parametrisation).
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8, DIGIT=1
  logic       start8, bin8, busy8, done8, bout8, ovf8, zero8;
  logic [7:0] a8, b8, d8;
  // WIDTH=3, DIGIT=1
  logic       start3, bin3, busy3, done3, bout3, ovf3, zero3;
  logic [2:0] a3, b3, d3;
  // WIDTH=16, DIGIT=4
  logic        start16, bin16, busy16, done16, bout16, ovf16, zero16;
  logic [15:0] a16, b16, d16;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_sub8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(3), .DIGIT(1)) u_sub3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .d(d3), .bout(bout3), .ovf(ovf3), .zero(zero3)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_sub16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .d(d16), .bout(bout16), .ovf(ovf16), .zero(zero16)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // sel: 0 = 8-bit instance, 1 = 3-bit instance, 2 = 16-bit instance
  task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic st);
    case (sel)
      0: begin a8 = a[7:0];  b8 = b[7:0];  bin8 = bin;  start8 = st;  end
      1: begin a3 = a[2:0];  b3 = b[2:0];  bin3 = bin;  start3 = st;  end
      default: begin a16 = a; b16 = b;     bin16 = bin; start16 = st; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic st);
    case (sel)
      0: start8 = st;
      1: start3 = st;
      default: start16 = st;
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done8;
      1: return done3;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy8;
      1: return busy3;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [15:0] get_d(input int sel);
    case (sel)
      0: return {8'h00, d8};
      1: return {13'h0000, d3};
      default: return d16;
    endcase
  endfunction

  // One complete operation with a one-cycle start. lat counts rising edges
  // from the accepting edge to the edge after which done is seen (bounded).
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, output int lat, output int busy_cycles,
                        output logic held);
    logic [15:0] d0;
    @(negedge clk);
    drive(sel, a, b, bin, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(sel, 1'b0);
    lat = 0;
    busy_cycles = 0;
    held = 1'b1;
    d0 = get_d(sel);
    while (!get_done(sel) && lat < 40) begin
      if (get_busy(sel)) busy_cycles++;
      if (get_d(sel) !== d0) held = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_d;
    logic       exp_bout;
    logic       exp_ovf;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[8];

  // Watchdog: a hung DUT must still end the run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, bcyc, done_cnt, ru, sa, sb, rs;
    logic held;
    vec_t v;
    logic [2:0] ea, eb;
    logic eb_in;
    logic [3:0] exp4;
    logic exp_ovf3;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(2, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs8", {20'h0, busy8, done8, d8, bout8, ovf8, zero8}, 32'h0);
    check("reset_outputs16", {12'h0, busy16, done16, d16, bout16, ovf16}, 32'h0);
    #2 rst_n = 1'b1;

    // Table-driven vectors, WIDTH=8 DIGIT=1
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      run_op(0, {8'h00, v.a}, {8'h00, v.b}, v.bin, lat, bcyc, held);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_result", i), {21'h0, d8, bout8, ovf8, zero8},
            {21'h0, v.exp_d, v.exp_bout, v.exp_ovf, v.exp_zero});
      if (i == 0) begin
        check("vec0_busy_cycles", 32'(bcyc), 32'd8);
        check("vec0_d_held_during_run", {31'h0, held}, 32'd1);
        check("vec0_busy_low_at_done", {31'h0, busy8}, 32'd0);
      end
      if (i == 1) check("vec1_d_held_during_run", {31'h0, held}, 32'd1);
    end

    // Exhaustive WIDTH=3 DIGIT=1
    for (int i = 0; i < 128; i++) begin
      ea = 3'(i >> 4);
      eb = 3'(i >> 1);
      eb_in = i[0];
      ru = int'(ea) - int'(eb) - int'(eb_in);
      exp4 = 4'(ru);
      sa = (ea > 3'd3) ? int'(ea) - 8 : int'(ea);
      sb = (eb > 3'd3) ? int'(eb) - 8 : int'(eb);
      rs = sa - sb - int'(eb_in);
      exp_ovf3 = (rs < -4) || (rs > 3);
      run_op(1, {13'h0, ea}, {13'h0, eb}, eb_in, lat, bcyc, held);
      check($sformatf("w3_a%0d_b%0d_bin%0d", ea, eb, eb_in),
            {26'h0, 32'(lat) == 32'd3, bout3, d3, ovf3},
            {26'h0, 1'b1, exp4, exp_ovf3});
    end

    // Parametrisation WIDTH=16 DIGIT=4
    run_op(2, 16'h1234, 16'h4321, 1'b0, lat, bcyc, held);
    check("w16_latency", 32'(lat), 32'd4);
    check("w16_result", {12'h0, d16, bout16, ovf16, zero16, 1'b0},
          {12'h0, 16'hCF13, 1'b1, 1'b0, 1'b0, 1'b0});
    check("w16_busy_cycles", 32'(bcyc), 32'd4);

    // Second start 3 cycles into RUN is ignored
    @(negedge clk);
    drive(0, 16'h005A, 16'h003C, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    drive(0, 16'h0001, 16'h0002, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    check("ignored_start_latency", 32'(lat), 32'd8);
    check("ignored_start_result", {23'h0, d8, bout8}, {23'h0, 8'h1E, 1'b0});
    @(posedge clk);
    @(negedge clk);
    check("ignored_start_idle_after", {30'h0, busy8, done8}, 32'd0);

    // Back-to-back: start held high through DONE
    drive(0, 16'h0010, 16'h0001, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!done8 && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    check("b2b_first_latency", 32'(lat), 32'd8);
    check("b2b_first_result", {22'h0, busy8, d8, bout8}, {22'h0, 1'b0, 8'h0F, 1'b0});
    a8 = 8'h20;
    b8 = 8'h05;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_swap", {30'h0, done8, busy8}, {30'h0, 1'b0, 1'b1});
    lat = 0;
    while (!done8 && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    check("b2b_second_latency", 32'(lat), 32'd8);
    check("b2b_second_result", {23'h0, d8, bout8}, {23'h0, 8'h1B, 1'b0});

    // Reset asserted mid-RUN
    @(negedge clk);
    drive(0, 16'h0033, 16'h0011, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {20'h0, busy8, done8, d8, bout8, ovf8, zero8}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) done_cnt++;
    end
    check("midrun_no_done_after_release", 32'(done_cnt), 32'd0);
    run_op(0, 16'h0033, 16'h0011, 1'b0, lat, bcyc, held);
    check("post_reset_latency", 32'(lat), 32'd8);
    check("post_reset_result", {21'h0, d8, bout8, ovf8, zero8},
          {21'h0, 8'h22, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor that computes d = a - b - bin, DIGIT bits per clock, starting from the LSB. Borrow is chained between digits in an internal register. It supersedes the single-bit combinational full subtractor wherever operands are wide and area matters more than latency. A start/busy/done handshake connects it to control FSMs and benches. It also reports a borrow-out, a signed overflow and a zero flag.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
DIGIT, 1, bits processed per clock; must divide WIDTH exactly. Elaboration error otherwise.

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only while busy=0
a      input   WIDTH  minuend; sampled with accepted start
b      input   WIDTH  subtrahend; sampled with accepted start
bin    input   1      borrow-in; sampled with accepted start
busy   output  1      high while a subtraction is in progress
done   output  1      one-cycle pulse when results become valid
d      output  WIDTH  difference, modulo 2^WIDTH
bout   output  1      borrow out of the MSB (unsigned a < b+bin)
ovf    output  1      signed two's-complement overflow
zero   output  1      high when d == 0

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - busy=0, done=0, d=0, bout=0, ovf=0, zero=0.
  - Internal operand/borrow/count registers are cleared.
- States are IDLE, RUN and DONE. N = WIDTH/DIGIT.
- IDLE -> RUN: at a rising edge with start=1.
  - Captures a, b and bin.
  - Clears the digit counter.
  - busy=1 from this edge.
- RUN, on each edge:
  - Processes the next DIGIT-bit slice, LSB slice first.
  - Each slice is a DIGIT-bit ripple of full-subtractor cells: diff = x ^ y ^ br; borrow = (~x & y) | (~(x ^ y) & br).
  - The slice borrow-out is registered as the borrow-in of the next slice.
  - Exactly N RUN edges occur. The Nth edge moves to DONE.
- DONE entry (the Nth RUN edge):
  - d, bout, ovf and zero are loaded in the same edge.
  - busy=0 and done=1 for exactly one cycle.
- Latency: results are valid and done=1 in the cycle after the N-th edge following the accepting edge. This is N clock edges after the start edge.
- DONE, next edge:
  - If start=1: accept a new operation and go to RUN. done drops and busy rises in the same edge (back-to-back).
  - Otherwise go to IDLE and drop done.
- Output holding: d/bout/ovf/zero hold their last completed value until the next completion. They do not change during RUN, and no partial results appear on d.
- start while busy=1 is ignored; no queueing. a/b/bin changes during RUN have no effect.
- ovf = (borrow into MSB cell) XOR bout. This equals the signed overflow of a - b - bin.
- zero is computed from the final d.
- bout = 1 if and only if {1'b0,a} < {1'b0,b} + bin.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and outputs read 0 after reset release.
- After rst_n deasserts, the first edge with start=1 is accepted normally.

Test Plan:
- Basic subtraction, WIDTH=8, DIGIT=1: a=8'h5A, b=8'h3C, bin=0 with 1-cycle start.
  - Required: done exactly 8 edges after the start edge.
  - Required: d=8'h1E, bout=0, ovf=0, zero=0.
  - Required: busy high for 8 cycles.
- Corner values, WIDTH=8:
  - a=8'h00, b=8'h01, bin=0 -> d=8'hFF, bout=1, ovf=0.
  - a=8'h80, b=8'h01 -> d=8'h7F, bout=0, ovf=1.
  - a=8'h10, b=8'h0F, bin=1 -> d=8'h00, zero=1, bout=0.
- Exhaustive check, WIDTH=3, DIGIT=1: loop all 128 {a,b,bin} combinations with one start per operation.
  - Required: {bout,d} == {1'b0,a} - {1'b0,b} - bin every time.
  - Required: ovf matches the signed-range check.
- Handshake, WIDTH=8, DIGIT=1:
  - Pulse start again 3 cycles into RUN with different operands. The second start is ignored, and the first result is unchanged.
  - Start held high through DONE gives a back-to-back op: done and busy swap in the same edge.
- Parametrisation: WIDTH=16, DIGIT=4, a=16'h1234, b=16'h4321, bin=0.
  - Required: done 4 edges after start.
  - Required: d=16'hCF13, bout=1, ovf=0.
- Reset mid-operation: drop rst_n asynchronously (off-edge) 4 cycles into RUN.
  - Required immediately: busy=0, done=0, d=0.
  - Required: no done pulse after release.
  - Required: the next start completes correctly.
